// File: rtl/umi_crossbar_arb.sv
// umi_crossbar_arb: request-side arbiter that builds the one-hot select
// matrix for the UMI N x N crossbar, with per-output packet locking.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   req        N*N request matrix, bit j*N+i = input i wants output j;
//              also qualifies the beat on input i as valid
//   last       last[i] = current beat of input i ends its packet
//   out_ready  out_ready[j] = sink of output j accepts a beat
//   sel        N*N one-hot select, same layout as req
//   in_ready   in_ready[i] = beat on input i is accepted this cycle
//   out_valid  out_valid[j] = granted input still presents a beat
//   out_last   out_last[j] = granted input's beat is its last
//
// Build option: define UMI_CROSSBAR_ARB_FIXED_PRIO_EN for fixed
// lowest-index-first priority instead of round-robin.
module umi_crossbar_arb #(
    parameter     TARGET = "DEFAULT",
    parameter int N      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*N-1:0] req,
    input  logic [N-1:0]   last,
    input  logic [N-1:0]   out_ready,
    output logic [N*N-1:0] sel,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   out_valid,
    output logic [N-1:0]   out_last
);

    localparam int          IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0] NW = (IW+1)'(N);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Index arithmetic modulo N without a divider.
    function automatic logic [IW-1:0] f_wrap(
        input logic [IW-1:0] base,
        input logic [IW-1:0] off
    );
        logic [IW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= NW) s = s - NW;
        return s[IW-1:0];
    endfunction

    state_t        r_state     [N];
    state_t        w_state_nxt [N];
    logic [IW-1:0] r_owner     [N];
    logic [IW-1:0] w_owner_nxt [N];
`ifndef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
    logic [IW-1:0] r_ptr       [N];
    logic [IW-1:0] w_ptr_nxt   [N];
`endif
    logic [IW-1:0] w_base      [N];

    logic [N-1:0]  w_row       [N];
    logic [N-1:0]  w_col       [N];
    logic [N-1:0]  w_cand      [N];
    logic [N-1:0]  w_sel_row   [N];
    logic [N-1:0]  w_inr_row   [N];
    logic [N-1:0]  w_inr_col   [N];
    logic [IW-1:0] w_win       [N];
    logic [N-1:0]  w_legal;
    logic [N-1:0]  w_found;
    logic [N-1:0]  w_busy;
    logic [N-1:0]  w_xfer;
    logic [N-1:0]  w_done;
    logic [N-1:0]  w_ov;
    logic [N-1:0]  w_ol;

    // Row j = requests for output j; column i = requests from input i.
    for (genvar gj = 0; gj < N; gj++) begin : g_mat
        assign w_row[gj] = req[gj*N +: N];
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign w_col[gi][gj]     = req[gj*N+gi];
            assign w_inr_col[gi][gj] = w_inr_row[gj][gi];
        end
    end

    // An input asking for several outputs at once takes part in no arbitration.
    for (genvar gi = 0; gi < N; gi++) begin : g_in
        assign w_legal[gi]  = $onehot0(w_col[gi]);
        assign in_ready[gi] = |w_inr_col[gi];
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_out

`ifdef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
        assign w_base[gj] = '0;
`else
        assign w_base[gj] = r_ptr[gj];
`endif

        assign w_cand[gj]  = w_row[gj] & w_legal;
        assign w_found[gj] = |w_cand[gj];
        assign w_busy[gj]  = (r_state[gj] == ST_BUSY);
        assign w_xfer[gj]  = w_busy[gj] & w_row[gj][r_owner[gj]]
                           & out_ready[gj];
        assign w_done[gj]  = w_xfer[gj] & last[r_owner[gj]];

        // Scan from the farthest offset down so the nearest hit wins.
        always_comb begin
            w_win[gj] = '0;
            for (int o = N-1; o >= 0; o--) begin
                if (w_cand[gj][f_wrap(w_base[gj], IW'(o))])
                    w_win[gj] = f_wrap(w_base[gj], IW'(o));
            end
        end

        // Reset gates the outputs so nothing transfers in the reset cycle.
        always_comb begin
            w_sel_row[gj] = '0;
            w_inr_row[gj] = '0;
            w_ov[gj]      = 1'b0;
            w_ol[gj]      = 1'b0;
            if (!reset && w_busy[gj]) begin
                w_sel_row[gj][r_owner[gj]] = 1'b1;
                w_inr_row[gj][r_owner[gj]] = out_ready[gj];
                w_ov[gj] = w_row[gj][r_owner[gj]];
                w_ol[gj] = last[r_owner[gj]];
            end
        end

        assign sel[gj*N +: N] = w_sel_row[gj];
        assign out_valid[gj]  = w_ov[gj];
        assign out_last[gj]   = w_ol[gj];

        always_comb begin
            w_state_nxt[gj] = r_state[gj];
            w_owner_nxt[gj] = r_owner[gj];
`ifndef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
            w_ptr_nxt[gj]   = r_ptr[gj];
`endif
            unique case (r_state[gj])
                ST_IDLE: begin
                    if (w_found[gj]) begin
                        w_state_nxt[gj] = ST_BUSY;
                        w_owner_nxt[gj] = w_win[gj];
                    end
                end
                ST_BUSY: begin
                    // Grant is held until the last beat actually moves.
                    if (w_done[gj]) begin
                        w_state_nxt[gj] = ST_IDLE;
`ifndef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
                        w_ptr_nxt[gj]   = f_wrap(r_owner[gj], IW'(1));
`endif
                    end
                end
                default: w_state_nxt[gj] = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state[gj] <= ST_IDLE;
                r_owner[gj] <= '0;
`ifndef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
                r_ptr[gj]   <= '0;
`endif
            end else begin
                r_state[gj] <= w_state_nxt[gj];
                r_owner[gj] <= w_owner_nxt[gj];
`ifndef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
                r_ptr[gj]   <= w_ptr_nxt[gj];
`endif
            end
        end
    end

endmodule

// File: tb/tb_umi_crossbar_arb.sv
// tb_umi_crossbar_arb: vector-table bench for umi_crossbar_arb (N = 4),
// with a scoreboard queue holding the expected outputs per cycle.
module tb_umi_crossbar_arb;

    localparam int N = 4;

`ifdef UMI_CROSSBAR_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   req;
    logic [3:0]    last;
    logic [3:0]    out_ready;
    logic [15:0]   sel;
    logic [3:0]    in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_last;

    always #5 clk = ~clk;

    umi_crossbar_arb #(.TARGET("DEFAULT"), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [15:0] sel;
        logic [3:0]  inr;
        logic [3:0]  ov;
        logic [3:0]  ol;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [3:0]  last;
        logic [3:0]  ordy;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(
        input logic        rst,
        input logic [15:0] rq,
        input logic [3:0]  ls,
        input logic [3:0]  ordy,
        input logic [15:0] esel,
        input logic [3:0]  einr,
        input logic [3:0]  eov,
        input logic [3:0]  eol
    );
        vec_t v;
        v.rst   = rst;
        v.req   = rq;
        v.last  = ls;
        v.ordy  = ordy;
        v.e.sel = esel;
        v.e.inr = einr;
        v.e.ov  = eov;
        v.e.ol  = eol;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = {sel, in_ready, out_valid, out_last};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got sel=%h inr=%h ov=%h ol=%h want sel=%h inr=%h ov=%h ol=%h",
                     name, a.sel, a.inr, a.ov, a.ol,
                     e.sel, e.inr, e.ov, e.ol);
        end
    endtask

    initial begin
        logic [3:0] order [3];
        int         cyc;
        exp_t       e;

        reset     = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 4'hF;
        order[0]  = 4'h1;
        order[1]  = 4'h2;
        order[2]  = 4'h8;

        // Reset with everything requested, then one-hot diagonal grants.
        add(1, 16'hFFFF, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(1, 16'hFFFF, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'hFFFF, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'hFFFF, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h8421, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h8421, 4'hF, 4'hF, 16'h8421, 4'hF, 4'hF, 4'hF);
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Input 2 -> output 1, three beats; then ptr[1]=3 decides 0 vs 3.
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0040, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0040, 4'h0, 4'hF, 16'h0040, 4'h4, 4'h2, 4'h0);
        add(0, 16'h0040, 4'h0, 4'hF, 16'h0040, 4'h4, 4'h2, 4'h0);
        add(0, 16'h0040, 4'h4, 4'hF, 16'h0040, 4'h4, 4'h2, 4'h2);
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0090, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0090, 4'h9, 4'hF,
            FP ? 16'h0010 : 16'h0080, FP ? 4'h1 : 4'h8, 4'h2, 4'h2);
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Inputs 0,1,3 -> output 0 with single-beat packets.
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            add(0, 16'h000B, 4'hF, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
            add(0, 16'h000B, 4'hF, 4'hF,
                {12'h000, FP ? 4'h1 : order[k%3]},
                FP ? 4'h1 : order[k%3], 4'h1, 4'h1);
        end
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Back-pressure on output 2 while input 1 waits behind the lock.
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0300, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0300, 4'h0, 4'hF, 16'h0100, 4'h1, 4'h4, 4'h0);
        add(0, 16'h0300, 4'h1, 4'hB, 16'h0100, 4'h0, 4'h4, 4'h4);
        add(0, 16'h0300, 4'h1, 4'hB, 16'h0100, 4'h0, 4'h4, 4'h4);
        add(0, 16'h0300, 4'h1, 4'hF, 16'h0100, 4'h1, 4'h4, 4'h4);
        add(0, 16'h0200, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0200, 4'h2, 4'hF, 16'h0200, 4'h2, 4'h4, 4'h4);
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Illegal multi-output request; then a held grant going illegal.
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0808, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0808, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0800, 4'h8, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h0800, 4'h0, 4'hF, 16'h0800, 4'h8, 4'h4, 4'h0);
        add(0, 16'h0808, 4'h8, 4'hF, 16'h0800, 4'h8, 4'h4, 4'h4);
        add(0, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        // Move ptr[3] to 3, start a packet, reset mid-packet, re-arbitrate.
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h4000, 4'h4, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'h4000, 4'h4, 4'hF, 16'h4000, 4'h4, 4'h8, 4'h8);
        add(0, 16'hA000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'hA000, 4'h0, 4'hF,
            FP ? 16'h2000 : 16'h8000, FP ? 4'h2 : 4'h8, 4'h8, 4'h0);
        add(1, 16'hA000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'hA000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);
        add(0, 16'hA000, 4'h0, 4'hF, 16'h2000, 4'h2, 4'h8, 4'h0);
        add(1, 16'h0000, 4'h0, 4'hF, 16'h0000, 4'h0, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            req       = tbl[i].req;
            last      = tbl[i].last;
            out_ready = tbl[i].ordy;
            sb.push_back(tbl[i].e);
            #2;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), e);
        end

        // Grant latency measured with a bounded wait.
        @(negedge clk);
        reset     = 1'b0;
        req       = 16'h0001;
        last      = 4'h1;
        out_ready = 4'hF;
        #2;
        cyc = 0;
        while (sel == 16'h0000 && cyc < 8) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        n_vec++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL grant_latency: got %0d cycles want 1", cyc);
        end
        e = '{sel: 16'h0001, inr: 4'h1, ov: 4'h1, ol: 4'h1};
        check("grant_beat", e);
        @(negedge clk);
        #2;
        e = '{sel: 16'h0000, inr: 4'h0, ov: 4'h0, ol: 4'h0};
        check("bubble", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
